ghr_ckpt: RTL and testbench
===========================

# ghr_ckpt

Speculative global history register with in-order checkpoint recovery, the parametrised successor to the plain GHR. The fetch stage shifts predicted directions into a speculative history, and the execute stage retires branches in program order into an architectural history. On a misprediction, the speculative history is repaired from a per-branch checkpoint FIFO. The block sits between the branch predictor (index/hash consumer of `ghr_data_o`) and the branch resolution unit.

## Interface
- `HISTORY_WIDTH`, 8, history bits; ≥ 2.
- `CKPT_DEPTH`, 4, maximum in-flight unresolved branches; power of two, ≥ 2.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `spec_en_i` in 1: predicted branch at fetch this cycle.
- `pred_taken_i` in 1: predicted direction.
- `spec_ready_o` out 1: push accepted this cycle.
- `resolve_en_i` in 1: oldest in-flight branch resolves this cycle.
- `resolve_taken_i` in 1: actual direction.
- `resolve_mispred_i` in 1: prediction was wrong.
- `flush_i` in 1: pipeline flush; discard all in-flight branches.
- `ghr_data_o` out `HISTORY_WIDTH`: speculative history.
- `ghr_arch_o` out `HISTORY_WIDTH`: committed history.
- `count_o` out `$clog2(CKPT_DEPTH+1)`: in-flight branch count.
- `empty_o` out 1: count = 0.
- `full_o` out 1: count = `CKPT_DEPTH`.
- `underflow_o` out 1: sticky; set by a resolve while empty.

## Operation
- Push, when `spec_en_i & spec_ready_o`:
  - Write the current `ghr_data_o` (pre-shift) into the FIFO at the write pointer.
  - Update `ghr_data_o <= {ghr_data_o[W-2:0], pred_taken_i}`.
  - Increment the count.
- `spec_ready_o = ~full_o | (resolve_en_i & ~empty_o)`, gated low by `flush_i` and by `resolve_en_i & resolve_mispred_i`.
- Resolve, when `resolve_en_i & ~empty_o`:
  - Pop the oldest checkpoint C.
  - Update `ghr_arch_o <= {ghr_arch_o[W-2:0], resolve_taken_i}`.
- Resolve with misprediction:
  - `ghr_data_o <= {C[W-2:0], resolve_taken_i}`.
  - The FIFO is cleared (all younger entries are wrong-path); count ← 0, pointers ← 0.
  - A simultaneous push is dropped.
- Resolve with correct prediction: the speculative history is untouched, and the count decrements unless a push occurs the same cycle.
- Resolve while empty: no state change except `underflow_o <= 1`. `underflow_o` clears only on reset.
- Flush (`flush_i`), highest priority:
  - `ghr_data_o <= ghr_arch_o` (value before any same-cycle resolve).
  - FIFO cleared.
  - Same-cycle push and resolve are both ignored, including the architectural update.
- Pointers wrap modulo `CKPT_DEPTH`. The count is kept separately, so full and empty are unambiguous.
- Priority order: flush > mispredict resolve > correct resolve + push.

## Timing
- Reset (asynchronous, immediate):
  - `ghr_data_o`, `ghr_arch_o`, `count_o`, pointers, and `underflow_o` = 0.
  - `empty_o` = 1; `full_o` = 0.
  - FIFO contents are don't-care.
- All state updates register on the rising edge of `clk_i` and are visible the next cycle.
- `spec_ready_o`, `empty_o`, and `full_o` are combinational from the count and the same-cycle inputs.
- Push-when-full is accepted only when a same-cycle correct resolve frees an entry. The count stays at `CKPT_DEPTH`.
- Reset asserted mid-operation abandons all in-flight checkpoints. The first cycle after deassertion behaves as the reset state.

## Configuration
- `GHR_CKPT_BYPASS_EN` defined: on a mispredict-resolve cycle, `ghr_data_o` combinationally presents the repaired value `{C[W-2:0], resolve_taken_i}`. The predictor can re-index with zero-cycle repair latency. On a flush cycle, `ghr_data_o` presents `ghr_arch_o`.
- `GHR_CKPT_BYPASS_EN` undefined: `ghr_data_o` is purely registered, and the repaired value appears one cycle later.
- Register contents are identical in both builds.

## Test plan
All scenarios use W=4, D=4, macro undefined unless stated.
- Reset, then idle → `ghr_data_o`=0, `ghr_arch_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0, `underflow_o`=0.
- Push 1, 1, 0 on consecutive cycles → `ghr_data_o`=4'b0110, `count_o`=3. Then resolve a correct taken → `ghr_arch_o`=4'b0001, `count_o`=2, `ghr_data_o` unchanged.
- Continue: resolve mispredicted with actual 0 (checkpoint 4'b0001) → `ghr_data_o`=4'b0010, `ghr_arch_o`=4'b0010, `count_o`=0, `empty_o`=1.
- Push 4 branches → `full_o`=1.
  - Then a 5th push alone → `spec_ready_o`=0, no change.
  - Then a push plus a correct resolve in the same cycle → accepted, `count_o` stays 4, write pointer wraps to 1.
- With 3 in flight, `ghr_arch_o`=4'b0011, assert `flush_i` together with `resolve_en_i` → `ghr_data_o`=4'b0011, `ghr_arch_o` unchanged, `count_o`=0.
- Resolve while empty → `underflow_o`=1 and stays 1 until `rst_ni` is pulsed low mid-stream, after which all outputs return to reset values.
- With the macro defined, a mispredict cycle with checkpoint 4'b0101 and actual 1 → `ghr_data_o`=4'b1011 in the same cycle.

Source files
------------

// File: rtl/ghr_ckpt_if.sv
// rtl/ghr_ckpt_if.sv - predictor/resolution-unit bundle for ghr_ckpt
// master: predictor and resolution side; slave: the checkpointed history block.
interface ghr_ckpt_if #(
  parameter int HISTORY_WIDTH = 8,
  parameter int CKPT_DEPTH    = 4
);
  localparam int CW = $clog2(CKPT_DEPTH + 1);

  logic                     spec_en_i;
  logic                     pred_taken_i;
  logic                     spec_ready_o;
  logic                     resolve_en_i;
  logic                     resolve_taken_i;
  logic                     resolve_mispred_i;
  logic                     flush_i;
  logic [HISTORY_WIDTH-1:0] ghr_data_o;
  logic [HISTORY_WIDTH-1:0] ghr_arch_o;
  logic [CW-1:0]            count_o;
  logic                     empty_o;
  logic                     full_o;
  logic                     underflow_o;

  modport master (
    output spec_en_i, pred_taken_i, resolve_en_i, resolve_taken_i,
           resolve_mispred_i, flush_i,
    input  spec_ready_o, ghr_data_o, ghr_arch_o, count_o, empty_o, full_o,
           underflow_o
  );

  modport slave (
    input  spec_en_i, pred_taken_i, resolve_en_i, resolve_taken_i,
           resolve_mispred_i, flush_i,
    output spec_ready_o, ghr_data_o, ghr_arch_o, count_o, empty_o, full_o,
           underflow_o
  );
endinterface

// File: rtl/ghr_ckpt.sv
// rtl/ghr_ckpt.sv - speculative GHR with in-order checkpoint FIFO recovery
// Optional GHR_CKPT_BYPASS_EN: repaired/flushed history is presented combinationally.
module ghr_ckpt #(
  parameter int HISTORY_WIDTH = 8,
  parameter int CKPT_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  ghr_ckpt_if.slave   bus
);
  localparam int W  = HISTORY_WIDTH;
  localparam int CW = $clog2(CKPT_DEPTH + 1);
  localparam int PW = $clog2(CKPT_DEPTH);

  logic [W-1:0]  ghr_q, ghr_d;
  logic [W-1:0]  arch_q, arch_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          underflow_q, underflow_d;

  logic [W-1:0]  ckpt_mem [CKPT_DEPTH];

  logic          empty, full, pop, mispred, ready, push;
  logic [W-1:0]  ckpt, repaired;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(CKPT_DEPTH));
  assign pop      = bus.resolve_en_i & ~empty;
  assign mispred  = pop & bus.resolve_mispred_i;
  assign ready    = (~full | pop) & ~bus.flush_i
                  & ~(bus.resolve_en_i & bus.resolve_mispred_i);
  assign push     = bus.spec_en_i & ready;
  assign ckpt     = ckpt_mem[rd_ptr_q];
  assign repaired = {ckpt[W-2:0], bus.resolve_taken_i};

  always_comb begin
    ghr_d       = ghr_q;
    arch_d      = arch_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q | (bus.resolve_en_i & empty & ~bus.flush_i);
    if (bus.flush_i) begin
      ghr_d    = arch_q;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (mispred) begin
      // Everything younger than the mispredicted branch is wrong-path.
      ghr_d    = repaired;
      arch_d   = {arch_q[W-2:0], bus.resolve_taken_i};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) begin
        arch_d   = {arch_q[W-2:0], bus.resolve_taken_i};
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
        ghr_d    = {ghr_q[W-2:0], bus.pred_taken_i};
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q       <= '0;
      arch_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      ghr_q       <= ghr_d;
      arch_q      <= arch_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underflow_q <= underflow_d;
    end
  end

  // Checkpoint storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) ckpt_mem[wr_ptr_q] <= ghr_q;
  end

`ifdef GHR_CKPT_BYPASS_EN
  assign bus.ghr_data_o = bus.flush_i ? arch_q : (mispred ? repaired : ghr_q);
`else
  assign bus.ghr_data_o = ghr_q;
`endif

  assign bus.spec_ready_o = ready;
  assign bus.ghr_arch_o   = arch_q;
  assign bus.count_o      = count_q;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.underflow_o  = underflow_q;
endmodule

// File: tb/tb_ghr_ckpt.sv
// tb/tb_ghr_ckpt.sv - directed table-driven bench for ghr_ckpt (W=4, D=4)
module tb_ghr_ckpt;
  localparam int W = 4;
  localparam int D = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  ghr_ckpt_if #(.HISTORY_WIDTH(W), .CKPT_DEPTH(D)) bus ();

  ghr_ckpt #(.HISTORY_WIDTH(W), .CKPT_DEPTH(D)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       se, pt, re, rt, rm, fl;
    logic       rdy;
    logic [3:0] ghr, arch;
    logic [2:0] cnt;
    logic       uf;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic se, pt, re, rt, rm, fl, rdy,
                              input logic [3:0] ghr, arch,
                              input logic [2:0] cnt, input logic uf);
    vec_t v;
    v.se = se; v.pt = pt; v.re = re; v.rt = rt; v.rm = rm; v.fl = fl;
    v.rdy = rdy; v.ghr = ghr; v.arch = arch; v.cnt = cnt; v.uf = uf;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic drive(input logic se, pt, re, rt, rm, fl);
    bus.spec_en_i = se; bus.pred_taken_i = pt; bus.resolve_en_i = re;
    bus.resolve_taken_i = rt; bus.resolve_mispred_i = rm; bus.flush_i = fl;
  endtask

  task automatic check_state(input string tag, input logic [3:0] ghr, arch,
                             input logic [2:0] cnt, input logic uf);
    check({tag, " ghr_data"},  int'(bus.ghr_data_o),  int'(ghr));
    check({tag, " ghr_arch"},  int'(bus.ghr_arch_o),  int'(arch));
    check({tag, " count"},     int'(bus.count_o),     int'(cnt));
    check({tag, " empty"},     int'(bus.empty_o),     int'(cnt == 3'd0));
    check({tag, " full"},      int'(bus.full_o),      int'(cnt == 3'(D)));
    check({tag, " underflow"}, int'(bus.underflow_o), int'(uf));
  endtask

  initial begin
    //            se pt re rt rm fl rdy ghr      arch     cnt uf
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 1, 4'b0011, 4'b0000, 2, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 1, 4'b0110, 4'b0000, 3, 0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0, 1, 4'b0110, 4'b0001, 2, 0);
    vecs[4]  = mk(0, 0, 1, 0, 1, 0, 0, 4'b0010, 4'b0010, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 1, 4'b0101, 4'b0010, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 4'b1010, 4'b0010, 2, 0);
    vecs[7]  = mk(1, 1, 0, 0, 0, 0, 1, 4'b0101, 4'b0010, 3, 0);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 1, 4'b1011, 4'b0010, 4, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 4'b1011, 4'b0010, 4, 0);
    vecs[10] = mk(1, 0, 1, 1, 0, 0, 1, 4'b0110, 4'b0101, 4, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 0, 1, 4'b0110, 4'b1011, 3, 0);
    vecs[12] = mk(0, 0, 1, 0, 0, 0, 1, 4'b0110, 4'b0110, 2, 0);
    vecs[13] = mk(0, 0, 1, 1, 0, 0, 1, 4'b0110, 4'b1101, 1, 0);
    vecs[14] = mk(0, 0, 1, 1, 1, 0, 0, 4'b0111, 4'b1011, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 1, 4'b1110, 4'b1011, 1, 0);
    vecs[16] = mk(1, 1, 1, 0, 0, 0, 1, 4'b1101, 4'b0110, 1, 0);
    vecs[17] = mk(1, 0, 1, 0, 0, 0, 1, 4'b1010, 4'b1100, 1, 0);
    vecs[18] = mk(1, 1, 1, 1, 0, 0, 1, 4'b0101, 4'b1001, 1, 0);
    vecs[19] = mk(1, 1, 1, 1, 0, 0, 1, 4'b1011, 4'b0011, 1, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 1, 4'b0110, 4'b0011, 2, 0);
    vecs[21] = mk(1, 1, 0, 0, 0, 0, 1, 4'b1101, 4'b0011, 3, 0);
    vecs[22] = mk(1, 1, 1, 1, 0, 1, 0, 4'b0011, 4'b0011, 0, 0);
    vecs[23] = mk(0, 0, 1, 1, 0, 0, 1, 4'b0011, 4'b0011, 0, 1);
    vecs[24] = mk(1, 1, 0, 0, 0, 0, 1, 4'b0111, 4'b0011, 1, 1);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 1, 4'b0111, 4'b0011, 1, 1);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check_state("reset", 4'b0000, 4'b0000, 3'd0, 1'b0);
    @(posedge clk_i);
    #1 check_state("idle", 4'b0000, 4'b0000, 3'd0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      drive(vecs[i].se, vecs[i].pt, vecs[i].re, vecs[i].rt, vecs[i].rm, vecs[i].fl);
      #1 check($sformatf("v%0d spec_ready", i), int'(bus.spec_ready_o), int'(vecs[i].rdy));
      @(posedge clk_i);
      #1 check_state($sformatf("v%0d", i), vecs[i].ghr, vecs[i].arch, vecs[i].cnt, vecs[i].uf);
    end

    // Asynchronous reset in the middle of a cycle with a push pending.
    @(negedge clk_i);
    drive(1, 1, 0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1 check_state("async_rst", 4'b0000, 4'b0000, 3'd0, 1'b0);
    @(posedge clk_i);
    #1 check_state("held_rst", 4'b0000, 4'b0000, 3'd0, 1'b0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 check_state("post_rst", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Build a checkpoint of 4'b0101, then mispredict it with actual 1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(1, (i != 1), 0, 0, 0, 0);
      @(posedge clk_i);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(0, 0, 1, 0, 0, 0);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1 check_state("pre_mis", 4'b1010, 4'b0000, 3'd1, 1'b0);
    @(negedge clk_i);
    drive(0, 0, 1, 1, 1, 0);
`ifdef GHR_CKPT_BYPASS_EN
    #1 check("bypass same_cycle ghr", int'(bus.ghr_data_o), int'(4'b1011));
`else
    #1 check("registered same_cycle ghr", int'(bus.ghr_data_o), int'(4'b1010));
`endif
    @(posedge clk_i);
    #1 check_state("post_mis", 4'b1011, 4'b0001, 3'd0, 1'b0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
